// File: rtl/player_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : player_motion_ctrl_if
// Brief    : Move strobe, enemy slots and player status between the button
//            debouncer / game logic and player_motion_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface player_motion_ctrl_if #(
    parameter int N_ENEMY = 5
);
    logic                   tick;
    logic [3:0]             dir;        // {up,down,left,right}
    logic [20*N_ENEMY-1:0]  enemy_pos;  // slot k: {h,v} at [20k+19:20k]
    logic [N_ENEMY-1:0]     enemy_vld;
    logic [19:0]            pos;
    logic                   blocked;
    logic                   hit;
    logic [3:0]             hit_id;
    logic [1:0]             state;

    modport master (
        output tick, dir, enemy_pos, enemy_vld,
        input  pos, blocked, hit, hit_id, state
    );

    modport slave (
        input  tick, dir, enemy_pos, enemy_vld,
        output pos, blocked, hit, hit_id, state
    );
endinterface
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_motion_ctrl
// Brief    : Player {h,v} position with tile-map wall checks, enemy overlap
//            detection and a knockback / cool-down state machine.
//            Optional macro PMC_DIAG_EN enables diagonal movement.
// Revision : 1.0 - initial release
// ============================================================================
module player_motion_ctrl #(
    parameter int N_ENEMY    = 5,
    parameter int STEP       = 2,
    parameter int SPR        = 32,
    parameter int TILE_LG2   = 5,
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int H_OFS      = 144,
    parameter int V_OFS      = 31,
    parameter int START_X    = 176,
    parameter int START_Y    = 63,
    parameter int KB_TICKS   = 8,
    parameter int COOL_TICKS = 32,
    parameter logic [0:MAP_W*MAP_H-1] MAP = {{MAP_W{1'b1}},
                                             {(MAP_H-2){{1'b1, {(MAP_W-2){1'b0}}, 1'b1}}},
                                             {MAP_W{1'b1}}}
) (
    input  logic                clk,
    input  logic                rst_n,
    player_motion_ctrl_if.slave bus
);
    localparam int c_ncell  = MAP_W * MAP_H;
    localparam int c_idx_w  = (c_ncell > 1) ? $clog2(c_ncell) : 1;
    localparam int c_kb_w   = $clog2(KB_TICKS + 1);
    localparam int c_cool_w = $clog2(COOL_TICKS + 1);

    localparam logic signed [10:0] c_step11 = 11'(STEP);
    localparam logic signed [10:0] c_far11  = 11'(SPR - 1);
    localparam logic signed [10:0] c_lead11 = 11'(SPR - 1 + STEP);
    localparam logic signed [10:0] c_spr11  = 11'(SPR);
    localparam logic signed [10:0] c_hofs11 = 11'(H_OFS);
    localparam logic signed [10:0] c_vofs11 = 11'(V_OFS);
    localparam logic [9:0]         c_step10 = 10'(STEP);
    localparam logic [c_kb_w-1:0]   c_kb_one   = c_kb_w'(1);
    localparam logic [c_cool_w-1:0] c_cool_one = c_cool_w'(1);

    localparam logic [1:0] c_up    = 2'd0;
    localparam logic [1:0] c_down  = 2'd1;
    localparam logic [1:0] c_left  = 2'd2;
    localparam logic [1:0] c_right = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KNOCK = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    function automatic logic probe_wall(input logic signed [10:0] px,
                                        input logic signed [10:0] py);
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        int                 col;
        int                 row;
        logic [c_idx_w-1:0] idx;
        dx  = px - c_hofs11;
        dy  = py - c_vofs11;
        col = int'(dx >>> TILE_LG2);
        row = int'(dy >>> TILE_LG2);
        idx = '0;
        if (dx[10] || dy[10] || col >= MAP_W || row >= MAP_H) begin
            probe_wall = 1'b1;
        end else begin
            idx        = c_idx_w'(row * MAP_W + col);
            probe_wall = MAP[idx];
        end
    endfunction

    // Both leading-edge corners of the sprite must land on open tiles.
    function automatic logic dir_clear(input logic [1:0] d,
                                       input logic [9:0] x,
                                       input logic [9:0] y);
        logic signed [10:0] sx, sy, ax, ay, bx, by;
        sx = $signed({1'b0, x});
        sy = $signed({1'b0, y});
        ax = sx;
        bx = sx;
        ay = sy;
        by = sy;
        case (d)
            c_up:    begin bx = sx + c_far11;  ay = sy - c_step11; by = ay; end
            c_down:  begin bx = sx + c_far11;  ay = sy + c_lead11; by = ay; end
            c_left:  begin ax = sx - c_step11; bx = ax; by = sy + c_far11; end
            default: begin ax = sx + c_lead11; bx = ax; by = sy + c_far11; end
        endcase
        dir_clear = !(probe_wall(ax, ay) || probe_wall(bx, by));
    endfunction

    function automatic logic [19:0] step_pos(input logic [1:0] d,
                                             input logic [9:0] x,
                                             input logic [9:0] y);
        case (d)
            c_up:    step_pos = {x, y - c_step10};
            c_down:  step_pos = {x, y + c_step10};
            c_left:  step_pos = {x - c_step10, y};
            default: step_pos = {x + c_step10, y};
        endcase
    endfunction

    state_t              r_state,    w_state_nxt;
    logic [9:0]          r_x,        w_x_nxt;
    logic [9:0]          r_y,        w_y_nxt;
    logic                r_blocked,  w_blk_nxt;
    logic                r_hit,      w_hit_nxt;
    logic [3:0]          r_hit_id,   w_hit_id_nxt;
    logic [c_kb_w-1:0]   r_kb_cnt,   w_kb_nxt;
    logic [c_cool_w-1:0] r_cool_cnt, w_cool_nxt;
    logic [1:0]          r_last_dir, w_last_nxt;

    logic [N_ENEMY-1:0]  w_ovl;
    logic                w_any_ovl;
    logic [3:0]          w_hit_sel;
    logic [19:0]         w_mv_pos;
    logic                w_mv_upd;
    logic                w_mv_blk;
    logic [1:0]          w_mv_last;
    logic [1:0]          w_kb_dir;
    logic                w_kb_clr;
    logic [19:0]         w_kb_pos;

    generate
        for (genvar k = 0; k < N_ENEMY; k++) begin : g_slot
            logic signed [10:0] w_dx, w_dy, w_adx, w_ady;
            assign w_dx  = $signed({1'b0, bus.enemy_pos[20*k+10 +: 10]}) - $signed({1'b0, r_x});
            assign w_dy  = $signed({1'b0, bus.enemy_pos[20*k +: 10]})    - $signed({1'b0, r_y});
            assign w_adx = w_dx[10] ? -w_dx : w_dx;
            assign w_ady = w_dy[10] ? -w_dy : w_dy;
            assign w_ovl[k] = bus.enemy_vld[k] && (w_adx < c_spr11) && (w_ady < c_spr11);
        end
    endgenerate

    // Scan downwards so the lowest overlapping slot is the one kept.
    always_comb begin
        w_hit_sel = 4'd0;
        for (int k = N_ENEMY - 1; k >= 0; k--) begin
            if (w_ovl[k]) w_hit_sel = 4'(k + 1);
        end
    end
    assign w_any_ovl = |w_ovl;

`ifdef PMC_DIAG_EN
    logic       w_v_act, w_h_act, w_v_clr, w_h_clr;
    logic [1:0] w_v_dir, w_h_dir;
    logic [19:0] w_v_step, w_h_step;

    // Axes are checked independently from the current position.
    always_comb begin
        w_v_act   = bus.dir[3] ^ bus.dir[2];
        w_h_act   = bus.dir[1] ^ bus.dir[0];
        w_v_dir   = bus.dir[3] ? c_up : c_down;
        w_h_dir   = bus.dir[1] ? c_left : c_right;
        w_v_clr   = w_v_act && dir_clear(w_v_dir, r_x, r_y);
        w_h_clr   = w_h_act && dir_clear(w_h_dir, r_x, r_y);
        w_v_step  = step_pos(w_v_dir, r_x, r_y);
        w_h_step  = step_pos(w_h_dir, r_x, r_y);
        w_mv_pos  = {r_x, r_y};
        w_mv_upd  = 1'b0;
        w_mv_blk  = r_blocked;
        w_mv_last = r_last_dir;
        if (w_v_clr) w_mv_pos[9:0]   = w_v_step[9:0];
        if (w_h_clr) w_mv_pos[19:10] = w_h_step[19:10];
        if (w_v_act || w_h_act) begin
            w_mv_upd  = 1'b1;
            w_mv_blk  = !(w_v_clr || w_h_clr);
            w_mv_last = w_h_act ? w_h_dir : w_v_dir;
        end
    end
`else
    logic [1:0] w_one_dir;
    logic       w_one_clr;

    always_comb begin
        w_one_dir = bus.dir[3] ? c_up : bus.dir[2] ? c_down : bus.dir[1] ? c_left : c_right;
        w_one_clr = dir_clear(w_one_dir, r_x, r_y);
        w_mv_pos  = {r_x, r_y};
        w_mv_upd  = 1'b0;
        w_mv_blk  = r_blocked;
        w_mv_last = r_last_dir;
        if ($onehot(bus.dir)) begin
            w_mv_upd  = 1'b1;
            w_mv_blk  = !w_one_clr;
            w_mv_last = w_one_dir;
            if (w_one_clr) w_mv_pos = step_pos(w_one_dir, r_x, r_y);
        end
    end
`endif

    // XOR with 1 swaps up<->down and left<->right in this encoding.
    assign w_kb_dir = r_last_dir ^ 2'b01;
    assign w_kb_clr = dir_clear(w_kb_dir, r_x, r_y);
    assign w_kb_pos = step_pos(w_kb_dir, r_x, r_y);

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_blk_nxt    = r_blocked;
        w_hit_nxt    = 1'b0;
        w_hit_id_nxt = r_hit_id;
        w_kb_nxt     = r_kb_cnt;
        w_cool_nxt   = r_cool_cnt;
        w_last_nxt   = r_last_dir;
        if (bus.tick) begin
            case (r_state)
                ST_IDLE, ST_COOL: begin
                    if (r_state == ST_IDLE && w_any_ovl) begin
                        w_hit_nxt    = 1'b1;
                        w_hit_id_nxt = w_hit_sel;
                        w_state_nxt  = ST_KNOCK;
                        w_kb_nxt     = c_kb_w'(KB_TICKS);
                    end else begin
                        {w_x_nxt, w_y_nxt} = w_mv_pos;
                        if (w_mv_upd) begin
                            w_blk_nxt  = w_mv_blk;
                            w_last_nxt = w_mv_last;
                        end
                        if (r_state == ST_COOL) begin
                            w_cool_nxt = r_cool_cnt - c_cool_one;
                            if (w_cool_nxt == '0) w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_KNOCK: begin
                    if (w_kb_clr) {w_x_nxt, w_y_nxt} = w_kb_pos;
                    w_kb_nxt = r_kb_cnt - c_kb_one;
                    if (w_kb_nxt == '0) begin
                        w_state_nxt = ST_COOL;
                        w_cool_nxt  = c_cool_w'(COOL_TICKS);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_x        <= 10'(START_X);
            r_y        <= 10'(START_Y);
            r_blocked  <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_id   <= 4'd0;
            r_kb_cnt   <= '0;
            r_cool_cnt <= '0;
            r_last_dir <= c_right;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_blocked  <= w_blk_nxt;
            r_hit      <= w_hit_nxt;
            r_hit_id   <= w_hit_id_nxt;
            r_kb_cnt   <= w_kb_nxt;
            r_cool_cnt <= w_cool_nxt;
            r_last_dir <= w_last_nxt;
        end
    end

    assign bus.pos     = {r_x, r_y};
    assign bus.blocked = r_blocked;
    assign bus.hit     = r_hit;
    assign bus.hit_id  = r_hit_id;
    assign bus.state   = r_state;
endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_motion_ctrl
// Brief    : Directed and randomised bench for player_motion_ctrl against a
//            behavioural model of movement, walls, hits and knockback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_motion_ctrl;
    localparam int N      = 5;
    localparam int STEP   = 2;
    localparam int SPR    = 32;
    localparam int MW     = 20;
    localparam int MH     = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_motion_ctrl_if #(.N_ENEMY(N)) bus ();
    player_motion_ctrl #(.N_ENEMY(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    int map_bits [MW*MH];
    int ex [N];
    int ey [N];
    bit ev [N];
    int m_x, m_y, m_blk, m_hit, m_hid, m_st, m_kb, m_cool, m_last; // last: 0 up 1 down 2 left 3 right

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic bit wall(input int px, input int py);
        int cx, cy;
        cx = px - 144;
        cy = py - 31;
        if (cx < 0 || cy < 0) return 1'b1;
        if (cx / 32 >= MW || cy / 32 >= MH) return 1'b1;
        return map_bits[(cy / 32) * MW + (cx / 32)] != 0;
    endfunction

    function automatic bit can_go(input int d, input int x, input int y);
        case (d)
            0: return !wall(x, y - STEP) && !wall(x + SPR - 1, y - STEP);
            1: return !wall(x, y + SPR - 1 + STEP) && !wall(x + SPR - 1, y + SPR - 1 + STEP);
            2: return !wall(x - STEP, y) && !wall(x - STEP, y + SPR - 1);
            default: return !wall(x + SPR - 1 + STEP, y) && !wall(x + SPR - 1 + STEP, y + SPR - 1);
        endcase
    endfunction

    task automatic go(input int d);
        case (d)
            0: m_y -= STEP;
            1: m_y += STEP;
            2: m_x -= STEP;
            default: m_x += STEP;
        endcase
    endtask

    task automatic model_reset();
        m_x = 176; m_y = 63; m_blk = 0; m_hit = 0; m_hid = 0;
        m_st = 0; m_kb = 0; m_cool = 0; m_last = 3;
    endtask

    task automatic model_move(input logic [3:0] d4);
        bit up, dn, lf, rt;
        {up, dn, lf, rt} = d4;
`ifdef PMC_DIAG_EN
        begin
            int vd, hd;
            bit cv, ch;
            vd = (up && !dn) ? 0 : (dn && !up) ? 1 : -1;
            hd = (lf && !rt) ? 2 : (rt && !lf) ? 3 : -1;
            cv = (vd >= 0) && can_go(vd, m_x, m_y);
            ch = (hd >= 0) && can_go(hd, m_x, m_y);
            if (cv) go(vd);
            if (ch) go(hd);
            if (vd >= 0 || hd >= 0) begin
                m_blk  = (cv || ch) ? 0 : 1;
                m_last = (hd >= 0) ? hd : vd;
            end
        end
`else
        if (int'(up) + int'(dn) + int'(lf) + int'(rt) == 1) begin
            int d;
            d = up ? 0 : dn ? 1 : lf ? 2 : 3;
            m_blk = can_go(d, m_x, m_y) ? 0 : 1;
            if (m_blk == 0) go(d);
            m_last = d;
        end
`endif
    endtask

    task automatic model_tick(input logic [3:0] d4);
        int hk;
        hk = -1;
        m_hit = 0;
        for (int k = 0; k < N; k++)
            if (hk < 0 && ev[k] && iabs(ex[k] - m_x) < SPR && iabs(ey[k] - m_y) < SPR) hk = k;
        if (m_st == 0 && hk >= 0) begin
            m_hit = 1; m_hid = hk + 1; m_st = 1; m_kb = 8;
        end else if (m_st == 1) begin
            int od;
            od = (m_last == 0) ? 1 : (m_last == 1) ? 0 : (m_last == 2) ? 3 : 2;
            if (can_go(od, m_x, m_y)) go(od);
            m_kb--;
            if (m_kb == 0) begin m_st = 2; m_cool = 32; end
        end else begin
            model_move(d4);
            if (m_st == 2) begin
                m_cool--;
                if (m_cool == 0) m_st = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pos"},     bus.pos,              {10'(m_x), 10'(m_y)});
        chk({tag, ".blocked"}, 20'(bus.blocked),     20'(m_blk));
        chk({tag, ".hit"},     20'(bus.hit),         20'(m_hit));
        chk({tag, ".hit_id"},  20'(bus.hit_id),      20'(m_hid));
        chk({tag, ".state"},   20'(bus.state),       20'(m_st));
    endtask

    task automatic drive_enemies();
        for (int k = 0; k < N; k++) begin
            bus.enemy_pos[20*k +: 20] = {10'(ex[k]), 10'(ey[k])};
            bus.enemy_vld[k]          = ev[k];
        end
    endtask

    task automatic cycle(input string tag, input bit t, input logic [3:0] d);
        drive_enemies();
        bus.tick = t;
        bus.dir  = d;
        if (t) model_tick(d);
        else   m_hit = 0;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        check_all(tag);
    endtask

    initial begin
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++)
                map_bits[r*MW + c] = (r == 0 || r == MH-1 || c == 0 || c == MW-1) ? 1 : 0;
        for (int k = 0; k < N; k++) begin ex[k] = 0; ey[k] = 0; ev[k] = 1'b0; end
        bus.tick = 1'b0;
        bus.dir  = 4'd0;
        drive_enemies();
        model_reset();

        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        cycle("up_wall", 1'b1, 4'b1000);
        chk("up_wall_exp", {bus.pos[19:0]}, {10'd176, 10'd63});
        chk("up_wall_blk", 20'(bus.blocked), 20'd1);

        for (int i = 0; i < 10; i++) cycle("right", 1'b1, 4'b0001);
        chk("right10_pos", bus.pos, {10'd196, 10'd63});
        chk("right10_blk", 20'(bus.blocked), 20'd0);
        cycle("dir0", 1'b1, 4'b0000);

        ex[2] = 210; ey[2] = 63; ev[2] = 1'b1;
        cycle("hit", 1'b1, 4'b0001);
        chk("hit_id3", 20'(bus.hit_id), 20'd3);
        chk("hit_knock", 20'(bus.state), 20'd1);
        cycle("hit_pulse_end", 1'b0, 4'b0000);

        for (int i = 0; i < 8; i++) cycle("knock", 1'b1, 4'b0001);
        chk("knock_pos", bus.pos, {10'd180, 10'd63});
        chk("knock_cool", 20'(bus.state), 20'd2);

        for (int i = 0; i < 4; i++)  cycle("cool_mv", 1'b1, 4'b0001);
        for (int i = 0; i < 28; i++) cycle("cool_wait", 1'b1, 4'b0000);
        chk("cool_idle", 20'(bus.state), 20'd0);
        cycle("rehit", 1'b1, 4'b0001);
        chk("rehit_pulse", 20'(bus.hit), 20'd1);

        for (int i = 0; i < 3; i++) cycle("knock2", 1'b1, 4'b0000);
        bus.tick = 1'b1;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst_pos", bus.pos, {10'd176, 10'd63});
        bus.tick = 1'b0;
        ev[2] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst");

        cycle("diag", 1'b1, 4'b1001);
`ifdef PMC_DIAG_EN
        chk("diag_pos", bus.pos, {10'd178, 10'd63});
`else
        chk("diag_pos", bus.pos, {10'd176, 10'd63});
`endif
        chk("diag_blk", 20'(bus.blocked), 20'd0);

        for (int i = 0; i < 800; i++) begin
            logic [3:0] d;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ev[k] = ($urandom_range(0, 2) == 0);
                    ex[k] = m_x + int'($urandom_range(0, 90)) - 45;
                    ey[k] = m_y + int'($urandom_range(0, 90)) - 45;
                end
            end
            d = ($urandom_range(0, 2) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            cycle("rand", $urandom_range(0, 4) != 0, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
